alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, registered successor to the team's combinational ALU.
- Adds a valid/ready handshake on input and output, status flags, a signed compare, shifts, and an iterative multi-cycle multiply.
- Sits between the register-file read stage and writeback of the datapath.
- Single-cycle ops sustain one result per clock; multiply stalls the input for WIDTH+1 cycles.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- OP_W, 5, opcode width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B (shift amount = low log2(WIDTH) bits)
- in_op  in  OP_W  opcode
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_result  out  WIDTH  result
- out_zero  out  1  result == 0
- out_neg  out  1  result MSB
- out_carry  out  1  carry (ADD) / no-borrow (SUB), else 0
- out_ovf  out  1  signed overflow (ADD/SUB); product truncated (MUL); else 0
- out_illegal  out  1  opcode not in the op list
- busy  out  1  multiply in progress

Behaviour:
- Ops:
  - 0 ZERO
  - 1 ADD
  - 2 SUB (a + ~b + 1)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOR
  - 7 SLT (signed, result 0/1)
  - 8 SLTU
  - 9 SLL
  - 10 SRL
  - 11 SRA
  - 12 MUL: unsigned, low WIDTH bits; ovf=1 iff the upper WIDTH product bits are nonzero
  - 13..2^OP_W-1: result 0, out_illegal=1, other flags 0
- All arithmetic is modulo 2^WIDTH. out_zero and out_neg are always derived from out_result.
- Reset (async, any state, including mid-multiply):
  - state IDLE, all outputs 0, out_valid=0, busy=0; in-flight multiply discarded.
  - in_ready=1 in the first cycle after rst deasserts.
- States: IDLE, MUL.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Acceptance = in_valid && in_ready at a rising edge.
- IDLE, accept non-MUL: result and flags registered at the accepting edge; out_valid=1 in the next cycle (latency 1).
- IDLE, accept MUL:
  - Latch operands, clear accumulator and counter, go to MUL, busy=1.
  - out_valid drops at the same edge if the previous result was taken, otherwise it holds.
- MUL:
  - One shift-add step per cycle for WIDTH cycles; in_ready=0.
  - On the edge after the last step: load result/flags, out_valid=1, busy=0, return to IDLE.
  - Result visible WIDTH+1 cycles after acceptance.
  - The final load waits while out_valid && !out_ready; this cannot occur, because acceptance required the output slot to be free or draining.
- Output hold: while out_valid && !out_ready, out_result and all flags are stable.
- out_valid clears on an out_ready edge unless a new result loads at that same edge.
- Simultaneous consume + accept (non-MUL): the register is overwritten with the new result, out_valid stays 1. This gives back-to-back throughput of 1 per cycle.
- Inputs are ignored when not accepted. in_a, in_b and in_op are sampled only at acceptance.
- Shift amount b mod WIDTH, e.g. b=33 shifts by 1 at WIDTH=32.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams (OP_ZERO..OP_MUL)
  - the state enum (IDLE, MUL)
  - a flag-bundle typedef {zero, neg, carry, ovf, illegal}
- One sub-module: alu_mul_iter.
  - Contains the shift-add multiplier with its own counter.
  - start/done interface, 2*WIDTH product output.
- Top level holds the FSM, the combinational single-cycle ops and the output register.

Test Plan (WIDTH=32):
- ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, ovf=1, neg=1, carry=0, zero=0; out_valid the cycle after accept.
- SUB 5-5 -> 0, zero=1, carry=1. SUB 0-1 -> 0xFFFFFFFF, carry=0, neg=1. SLT 0xFFFFFFFF,1 -> 1. SLTU same operands -> 0.
- MUL 0x00010000*0x00010000 -> 0x00000000, ovf=1; MUL 7*6 -> 42, ovf=0. For each: busy=1 and in_ready=0 for 32 cycles, out_valid at cycle 33 after accept.
- Shifts and illegal ops:
  - SRA 0x80000000 by 31 -> 0xFFFFFFFF.
  - SLL 1 by b=33 -> 0x00000002.
  - op=20 -> result 0, illegal=1.
- Back-pressure:
  - out_ready=1 with 4 back-to-back ADDs -> 4 results on 4 consecutive cycles.
  - out_ready=0 -> second op stalls (in_ready=0) and the first result is held stable until out_ready=1.
- Reset during a MUL at iteration 10 -> out_valid=0, busy=0 immediately. After release, in_ready=1, and ADD 2+3 -> 5 one cycle after accept.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM states and the flag bundle for alu_pipe       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_pkg;

    localparam int OP_ZERO = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_AND  = 3;
    localparam int OP_OR   = 4;
    localparam int OP_XOR  = 5;
    localparam int OP_NOR  = 6;
    localparam int OP_SLT  = 7;
    localparam int OP_SLTU = 8;
    localparam int OP_SLL  = 9;
    localparam int OP_SRL  = 10;
    localparam int OP_SRA  = 11;
    localparam int OP_MUL  = 12;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic illegal;
    } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_mul_iter : iterative unsigned shift-add multiplier, 1 bit/cycle  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               run_q;

    // Once all steps are done the product is held until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q && (cnt_q != CNT_W'(WIDTH))) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign done_o    = run_q && (cnt_q == CNT_W'(WIDTH));
    assign product_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_pipe : registered ALU with valid/ready handshake and iterative   |
// |            multiply; one result per clock for single-cycle ops.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             out_illegal,
    output logic             busy
);

    localparam int SH_W = $clog2(WIDTH);

    state_t             state_q;
    logic [WIDTH-1:0]   result_q;
    alu_flags_t         flags_q;
    logic               valid_q;
    logic               busy_q;

    logic               accept;
    logic               is_mul;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]         add_sum;
    logic [WIDTH:0]         sub_diff;
    logic [SH_W-1:0]        shamt;
    logic signed [WIDTH-1:0] a_signed;
    logic signed [WIDTH-1:0] b_signed;
    logic [WIDTH-1:0]       alu_result_d;
    alu_flags_t             alu_flags_d;
    logic [WIDTH-1:0]       mul_result_d;
    alu_flags_t             mul_flags_d;

    assign in_ready  = (state_q == ST_IDLE) && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (in_op == OP_W'(OP_MUL));
    assign mul_start = accept && is_mul;

    assign add_sum  = {1'b0, in_a} + {1'b0, in_b};
    assign sub_diff = {1'b0, in_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt    = in_b[SH_W-1:0];
    assign a_signed = in_a;
    assign b_signed = in_b;

    always_comb begin
        alu_result_d        = '0;
        alu_flags_d         = '0;
        case (in_op)
            OP_W'(OP_ZERO): alu_result_d = '0;
            OP_W'(OP_ADD): begin
                alu_result_d      = add_sum[WIDTH-1:0];
                alu_flags_d.carry = add_sum[WIDTH];
                alu_flags_d.ovf   = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                                    (add_sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_W'(OP_SUB): begin
                alu_result_d      = sub_diff[WIDTH-1:0];
                alu_flags_d.carry = sub_diff[WIDTH];
                alu_flags_d.ovf   = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                                    (sub_diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_W'(OP_AND):  alu_result_d = in_a & in_b;
            OP_W'(OP_OR):   alu_result_d = in_a | in_b;
            OP_W'(OP_XOR):  alu_result_d = in_a ^ in_b;
            OP_W'(OP_NOR):  alu_result_d = ~(in_a | in_b);
            OP_W'(OP_SLT):  alu_result_d = {{(WIDTH-1){1'b0}}, (a_signed < b_signed)};
            OP_W'(OP_SLTU): alu_result_d = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
            OP_W'(OP_SLL):  alu_result_d = in_a << shamt;
            OP_W'(OP_SRL):  alu_result_d = in_a >> shamt;
            OP_W'(OP_SRA):  alu_result_d = a_signed >>> shamt;
            // MUL results come from the iterative unit, not this path.
            OP_W'(OP_MUL):  alu_result_d = '0;
            default:        alu_flags_d.illegal = 1'b1;
        endcase
        alu_flags_d.zero = (alu_result_d == '0);
        alu_flags_d.neg  = alu_result_d[WIDTH-1];
    end

    always_comb begin
        mul_result_d        = mul_product[WIDTH-1:0];
        mul_flags_d         = '0;
        mul_flags_d.zero    = (mul_result_d == '0);
        mul_flags_d.neg     = mul_result_d[WIDTH-1];
        mul_flags_d.ovf     = |mul_product[2*WIDTH-1:WIDTH];
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (in_a),
        .b_i       (in_b),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && !is_mul) begin
                        result_q <= alu_result_d;
                        flags_q  <= alu_flags_d;
                        valid_q  <= 1'b1;
                    end else begin
                        valid_q <= valid_q && !out_ready;
                        if (accept) begin
                            state_q <= ST_MUL;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done && !(valid_q && !out_ready)) begin
                        result_q <= mul_result_d;
                        flags_q  <= mul_flags_d;
                        valid_q  <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else begin
                        valid_q <= valid_q && !out_ready;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign out_valid   = valid_q;
    assign out_result  = result_q;
    assign out_zero    = flags_q.zero;
    assign out_neg     = flags_q.neg;
    assign out_carry   = flags_q.carry;
    assign out_ovf     = flags_q.ovf;
    assign out_illegal = flags_q.illegal;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_pipe : directed self-checking bench for alu_pipe (WIDTH=32)   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_pipe;

    localparam int WIDTH = 32;
    localparam int OP_W  = 5;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OP_W-1:0]  in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_ovf;
    logic             out_illegal;
    logic             busy;

    int checks = 0;
    int passed = 0;

    alu_pipe #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_neg     (out_neg),
        .out_carry   (out_carry),
        .out_ovf     (out_ovf),
        .out_illegal (out_illegal),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags packed as {zero, neg, carry, ovf, illegal}.
    function automatic logic [4:0] flags();
        return {out_zero, out_neg, out_carry, out_ovf, out_illegal};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present one op at a negedge and let it be accepted at the next posedge.
    task automatic issue(input string tag, input int op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_W'(op);
        in_a     = a;
        in_b     = b;
        #1 check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic single(input string tag, input int op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic [4:0] fl);
        issue(tag, op, a, b);
        check({tag, ".valid"},  64'(out_valid), 64'd1);
        check({tag, ".result"}, 64'(out_result), 64'(res));
        check({tag, ".flags"},  64'(flags()), 64'(fl));
    endtask

    task automatic mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [4:0] fl);
        issue(tag, 12, a, b);
        for (int k = 1; k <= WIDTH; k++) begin
            @(posedge clk);
            #1 check($sformatf("%s.iter%0d", tag, k), 64'({busy, in_ready, out_valid}), 64'b100);
        end
        @(posedge clk);
        #1;
        check({tag, ".done"},   64'({busy, out_valid}), 64'b01);
        check({tag, ".result"}, 64'(out_result), 64'(res));
        check({tag, ".flags"},  64'(flags()), 64'(fl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        #1;
        check("reset.outs", 64'({out_valid, busy, flags()}), 64'd0);
        check("reset.result", 64'(out_result), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 check("post_reset.in_ready", 64'(in_ready), 64'd1);

        single("add_ovf",  1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01010);
        single("add_wrap", 1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10100);
        single("sub_zero", 2, 32'd5, 32'd5, 32'h00000000, 5'b10100);
        single("sub_neg",  2, 32'd0, 32'd1, 32'hFFFFFFFF, 5'b01000);
        single("and",      3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b01000);
        single("xor",      5, 32'hA5A5A5A5, 32'hFFFFFFFF, 32'h5A5A5A5A, 5'b00000);
        single("nor",      6, 32'h0, 32'h0, 32'hFFFFFFFF, 5'b01000);
        single("slt",      7, 32'hFFFFFFFF, 32'd1, 32'd1, 5'b00000);
        single("sltu",     8, 32'hFFFFFFFF, 32'd1, 32'd0, 5'b10000);
        single("sll33",    9, 32'd1, 32'd33, 32'd2, 5'b00000);
        single("srl",     10, 32'h80000000, 32'd4, 32'h08000000, 5'b00000);
        single("sra31",   11, 32'h80000000, 32'd31, 32'hFFFFFFFF, 5'b01000);
        single("illegal", 20, 32'h12345678, 32'h1, 32'h0, 5'b10001);
        single("zero_op",  0, 32'h12345678, 32'h1, 32'h0, 5'b10000);

        mul("mul_big", 32'h00010000, 32'h00010000, 32'h00000000, 5'b10010);
        mul("mul_7x6", 32'd7, 32'd6, 32'd42, 5'b00000);

        // Back-to-back: one result per cycle with the consumer always ready.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("b2b.valid%0d", i - 1), 64'(out_valid), 64'd1);
                check($sformatf("b2b.res%0d", i - 1), 64'(out_result), 64'(100 + 2 * (i - 1)));
            end
            in_valid = 1'b1;
            in_op    = OP_W'(1);
            in_a     = 32'(100 + i);
            in_b     = 32'(i);
            #1 check($sformatf("b2b.ready%0d", i), 64'(in_ready), 64'd1);
        end
        @(negedge clk);
        check("b2b.valid3", 64'(out_valid), 64'd1);
        check("b2b.res3", 64'(out_result), 64'd106);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b.drained", 64'(out_valid), 64'd0);

        // Back-pressure: first result held, second op stalled.
        out_ready = 1'b0;
        issue("bp.first", 1, 32'd10, 32'd20);
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_W'(2);
        in_a     = 32'd9;
        in_b     = 32'd4;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp.stall%0d", k), 64'({in_ready, out_valid}), 64'b01);
            check($sformatf("bp.hold%0d", k), 64'(out_result), 64'd30);
            check($sformatf("bp.holdfl%0d", k), 64'(flags()), 64'b00000);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 check("bp.release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp.second_valid", 64'(out_valid), 64'd1);
        check("bp.second_res", 64'(out_result), 64'd5);
        @(posedge clk);
        #1 check("bp.consumed", 64'(out_valid), 64'd0);

        // Reset in the middle of a multiply.
        issue("rst_mul", 12, 32'd3, 32'd5);
        repeat (10) @(posedge clk);
        #1 check("rst_mul.busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        #1 check("rst_mul.cleared", 64'({out_valid, busy}), 64'b00);
        @(negedge clk);
        rst = 1'b0;
        #1 check("rst_mul.in_ready", 64'(in_ready), 64'd1);
        single("after_rst_add", 1, 32'd2, 32'd3, 32'd5, 5'b00000);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
